// File: rtl/serial_tx_scheduler.sv
// ============================================================================
// serial_tx_scheduler
//
// Round-robin arbiter and serializer controller for the filter's 12-bit output
// shift register. Channels hand over finished words with valid/ready; the
// granted word is loaded into the shift register and then shifted out MSB
// first. Each bit is held for CLK_DIV cycles, and GAP_CYCLES idle cycles
// follow every frame.
//
// Parameters:
//   NUM_CH      number of requesting channels (2..8)
//   CLK_DIV     clk cycles per serial bit (>= 1)
//   GAP_CYCLES  idle cycles after each frame (>= 0)
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   ch_data     channel c word at [12c+11:12c]
//   ch_valid    channel c has a word pending
//   ch_ready    one-hot accept pulse (word moves when valid & ready)
//   load_data   shift register parallel load
//   shift       shift register rotate-left
//   data_in     word presented to the shift register during a load
//   ch_id       channel whose word is being serialized
//   frame_sync  high during the first bit period of a frame
//   bit_strobe  high on the last cycle of each bit period
//   busy        high whenever the controller is not idle
// ============================================================================
module serial_tx_scheduler #(
    parameter int NUM_CH     = 2,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 2,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*12-1:0]   ch_data,
    input  logic [NUM_CH-1:0]      ch_valid,
    output logic [NUM_CH-1:0]      ch_ready,
    output logic                   load_data,
    output logic                   shift,
    output logic [11:0]            data_in,
    output logic [CH_W-1:0]        ch_id,
    output logic                   frame_sync,
    output logic                   bit_strobe,
    output logic                   busy
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t            state_q, state_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]   ch_id_q, ch_id_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic [NUM_CH-1:0] ready_c;
    logic              load_c;
    logic              shift_c;
    logic              strobe_c;
    logic [11:0]       data_c;
    logic              found;
    logic [CH_W-1:0]   grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            ch_id_q   <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            ch_id_q   <= ch_id_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Round-robin search starts at rr_ptr and wraps, so the channel after the
    // last grant gets first chance. The grant, ready pulse and load are all
    // decided in the same IDLE cycle.
    always_comb begin
        logic [CH_W-1:0] idx;

        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        ch_id_d   = ch_id_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        ready_c   = '0;
        load_c    = 1'b0;
        shift_c   = 1'b0;
        strobe_c  = 1'b0;
        data_c    = '0;
        found     = 1'b0;
        grant     = '0;
        idx       = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_ptr_q) + i) % NUM_CH);
            if (!found && ch_valid[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    ready_c[grant] = 1'b1;
                    load_c         = 1'b1;
                    data_c         = ch_data[int'(grant)*12 +: 12];
                    ch_id_d        = grant;
                    rr_ptr_d       = (grant == CH_LAST) ? '0 : grant + CH_W'(1);
                    div_cnt_d      = '0;
                    bit_cnt_d      = '0;
                    gap_cnt_d      = '0;
                    state_d        = SEND;
                end
            end

            // The final bit gets its strobe but no shift; the register keeps
            // presenting bit 0 of the word until the next load.
            SEND: begin
                if (div_cnt_q == DIV_LAST) begin
                    strobe_c = 1'b1;
                    if (bit_cnt_q != 4'd11) begin
                        shift_c   = 1'b1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        div_cnt_d = '0;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end

            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Every output, including the combinational handshake path, is forced
    // low while rst is high so nothing is accepted in the reset cycle.
    assign ch_ready   = rst ? '0 : ready_c;
    assign load_data  = !rst && load_c;
    assign shift      = !rst && shift_c;
    assign data_in    = rst ? '0 : data_c;
    assign ch_id      = rst ? '0 : ch_id_q;
    assign bit_strobe = !rst && strobe_c;
    assign frame_sync = !rst && (state_q == SEND) && (bit_cnt_q == 4'd0);
    assign busy       = !rst && (state_q != IDLE);

endmodule

// File: doc/serial_tx_scheduler.md
# serial_tx_scheduler

Arbitrating serializer controller for the 12-bit output shift register of the digital filter. Accepts finished 12-bit words from NUM_CH filter channels over valid/ready handshakes and grants the single shift register to one channel at a time, round-robin. It drives the shift register's load/shift controls so each word leaves MSB-first at a programmable bit rate, and emits frame and bit-sample strobes for the downstream serial link.

## Interface
- NUM_CH, 2: number of requesting channels (2..8).
- CLK_DIV, 4: clk cycles each serial bit is held (>= 1).
- GAP_CYCLES, 2: idle cycles inserted after each frame (>= 0).
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- ch_data  input  NUM_CH*12  channel c word at [12c+11:12c].
- ch_valid  input  NUM_CH  channel c has a word pending.
- ch_ready  output  NUM_CH  one-hot accept pulse; word transfers when valid and ready are both high.
- load_data  output  1  to shift register load_data.
- shift  output  1  to shift register shift.
- data_in  output  12  to shift register data_in.
- ch_id  output  clog2(NUM_CH) (min 1)  channel currently being serialized.
- frame_sync  output  1  high during the first bit period of a frame.
- bit_strobe  output  1  high on the last cycle of each bit period; serial_data_out is stable there.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Shift register model: load puts data_in[11] on serial_data_out the next cycle. Each shift rotates left and presents the next lower bit.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any ch_valid is set, grant the first valid channel at or after rr_ptr, searching upward with wrap.
  - In the same cycle, ch_ready[g]=1, load_data=1 and data_in=ch_data[g]. These are combinational from registered state, rr_ptr and ch_valid.
  - Register ch_id<=g and rr_ptr<=(g+1) mod NUM_CH. Clear div_cnt and bit_cnt. Go to SEND.
  - If no channel is valid, stay in IDLE.
- SEND: div_cnt counts 0..CLK_DIV-1. When div_cnt==CLK_DIV-1:
  - bit_strobe=1.
  - If bit_cnt<11: shift=1, bit_cnt++, div_cnt<=0.
  - Else (bit_cnt==11): no shift; go to GAP, or to IDLE if GAP_CYCLES==0.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- frame_sync=1 exactly when state==SEND and bit_cnt==0.
- Outside the conditions above, ch_ready, load_data and shift are 0. data_in is 0 when not loading.
- ch_valid is sampled only in IDLE. A valid that is raised and dropped during SEND or GAP is never granted.
- A non-granted valid channel keeps its word. ch_ready stays low for it until it is granted.
- load_data and shift are never asserted in the same cycle.
- Reset values: state IDLE, rr_ptr 0, ch_id 0, counters 0. All outputs are 0 during the rst cycle, including the combinational ones, which are gated by rst.
- Reset mid-frame aborts the frame; the word is dropped and nothing is re-requested. The shift register contents are left stale, and the next load overwrites them.

## Timing
- Word accepted in cycle T (ch_ready high).
- Bit k (k=0 is MSB) is on serial_data_out in cycles T+1+k*CLK_DIV through T+(k+1)*CLK_DIV.
- bit_strobe fires in cycle T+(k+1)*CLK_DIV.
- SEND occupies T+1..T+12*CLK_DIV. GAP occupies the next GAP_CYCLES cycles.
- Earliest next accept is T+12*CLK_DIV+GAP_CYCLES+1, giving a frame period of 12*CLK_DIV+GAP_CYCLES+1 (51 cycles at defaults).
- Exactly 11 shift pulses and 12 bit_strobe pulses per frame.
- frame_sync is high for CLK_DIV cycles.

## Test plan
- Single word, defaults: ch_data[11:0]=0xA5C, ch_valid[0]=1 for one cycle at T.
  - ch_ready[0] pulses at T only.
  - serial_data_out reads 1010_0101_1100 on the 12 bit_strobe cycles at T+4, T+8, …, T+48.
  - frame_sync is high T+1..T+4; busy is high T+1..T+50.
- Both channels valid continuously (0x111 on ch0, 0x222 on ch1):
  - grants alternate 0,1,0,1 with ch_id matching;
  - accepts occur at T, T+51, T+102.
- Fairness: after ch1 is granted, only ch1 is valid. ch1 is granted again at the next IDLE; rr_ptr=0 does not stall.
- CLK_DIV=1, GAP_CYCLES=0, ch0 always valid: accepts every 13 cycles, 11 consecutive shift cycles, frame_sync high for 1 cycle.
- Reset mid-frame: assert rst for 1 cycle during bit 5.
  - Next cycle: all outputs 0 and state IDLE.
  - A pending ch1 word is then accepted with rr_ptr reset to 0; ch0 is preferred if both are valid.
- Late request: ch1 valid raised and dropped entirely within SEND → never granted, ch_ready[1] never high.
